// File: rtl/viterbi_dec_hard_1_2.sv
// Hard-decision rate-1/2 Viterbi decoder: full-parallel ACS with register-exchange survivors.
// Optional VITERBI_ERRCNT_EN adds err_cnt, the accumulated Hamming distance of the best path.
module viterbi_dec_hard_1_2 #(
  parameter int         K        = 4,
  parameter logic [7:0] G0_OCT   = 8'o17,
  parameter logic [7:0] G1_OCT   = 8'o13,
  parameter int         TB_DEPTH = 20,
  parameter int         PM_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [1:0]  in_sym,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic        out_bit,
`ifdef VITERBI_ERRCNT_EN
  output logic [15:0] err_cnt,
`endif
  output logic        busy
);

  localparam int M     = K - 1;
  localparam int NS    = 1 << M;
  localparam int D     = TB_DEPTH;
  localparam int CNT_W = $clog2(D + 1);
  localparam int IDX_W = $clog2(D);

  localparam logic [PM_W-1:0]  PM_MAX   = '1;
  localparam logic [K-1:0]     G0M      = G0_OCT[K-1:0];
  localparam logic [K-1:0]     G1M      = G1_OCT[K-1:0];
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(D);
  localparam logic [CNT_W-1:0] TAP_FILL = CNT_W'(D - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q;
  logic [PM_W-1:0]  pm_q     [NS];
  logic [D-1:0]     surv_q   [NS];
  logic [M-1:0]     best_q;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] rem_q;
  logic [D-1:0]     frz_q;
  logic             out_valid_q;
  logic             out_bit_q;

  logic [PM_W-1:0]  pm_acs   [NS];
  logic [PM_W-1:0]  pm_d     [NS];
  logic [D-1:0]     surv_d   [NS];
  logic [PM_W-1:0]  min_pm;
  logic [M-1:0]     best_d;
  logic [D-1:0]     best_surv;
  logic [CNT_W-1:0] fill_d;
  logic [CNT_W-1:0] fill_post;
  logic [CNT_W-1:0] rem_init;
  logic [CNT_W-1:0] rem_m1;
  logic             acc;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + (PM_W+1)'(b);
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // One add-compare-select per destination state s'; predecessors are {s'[M-2:0], x}.
  for (genvar gi = 0; gi < NS; gi++) begin : g_acs
    localparam int P0 = (gi << 1) % NS;
    localparam int P1 = P0 + 1;
    localparam int BI = (gi >> (M - 1)) & 1;
    localparam logic [K-1:0] R0 = K'((BI << M) | P0);
    localparam logic [K-1:0] R1 = K'((BI << M) | P1);
    localparam logic [1:0]   S0 = {^(R0 & G0M), ^(R0 & G1M)};
    localparam logic [1:0]   S1 = {^(R1 & G0M), ^(R1 & G1M)};

    logic [1:0]      bm0;
    logic [1:0]      bm1;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;
    logic            sel;
    logic [D-1:0]    sw;

    assign bm0 = {1'b0, in_sym[1] ^ S0[1]} + {1'b0, in_sym[0] ^ S0[0]};
    assign bm1 = {1'b0, in_sym[1] ^ S1[1]} + {1'b0, in_sym[0] ^ S1[0]};
    assign c0  = sat_add(pm_q[P0], bm0);
    assign c1  = sat_add(pm_q[P1], bm1);
    // Strict compare: a tie keeps the x=0 predecessor.
    assign sel = (c1 < c0);
    assign pm_acs[gi] = sel ? c1 : c0;
    assign sw         = sel ? surv_q[P1] : surv_q[P0];
    assign surv_d[gi] = {sw[D-2:0], 1'(BI)};
    assign pm_d[gi]   = pm_acs[gi] - min_pm;
  end

  // Lowest index wins among equal minima.
  always_comb begin
    min_pm = pm_acs[0];
    best_d = '0;
    for (int i = 1; i < NS; i++) begin
      if (pm_acs[i] < min_pm) begin
        min_pm = pm_acs[i];
        best_d = M'(i);
      end
    end
  end

  assign best_surv = surv_d[best_d];
  assign acc       = in_valid && (state_q == RUN);
  assign fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  assign fill_post = acc ? fill_d : fill_q;
  assign rem_init  = (fill_post > TAP_FILL) ? TAP_FILL : fill_post;
  assign rem_m1    = rem_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      fill_q      <= '0;
      rem_q       <= '0;
      frz_q       <= '0;
      best_q      <= '0;
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= '0;
        surv_q[i] <= '0;
      end
    end else if (start) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      fill_q      <= '0;
      rem_q       <= '0;
      best_q      <= '0;
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_MAX;
        surv_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (acc) begin
            pm_q   <= pm_d;
            surv_q <= surv_d;
            fill_q <= fill_d;
            best_q <= best_d;
            if (fill_q >= TAP_FILL) begin
              out_valid_q <= 1'b1;
              out_bit_q   <= best_surv[D-1];
            end
          end
          if (flush) begin
            // Freeze the best survivor; the bits still younger than the tap drain from it.
            frz_q   <= acc ? best_surv : surv_q[best_q];
            rem_q   <= rem_init;
            state_q <= (rem_init == '0) ? IDLE : FLUSH;
          end
        end
        FLUSH: begin
          out_valid_q <= 1'b1;
          out_bit_q   <= frz_q[rem_m1[IDX_W-1:0]];
          rem_q       <= rem_m1;
          if (rem_q == CNT_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_q;
  logic [16:0] err_sum;

  // After normalisation the previous best metric is zero, so min_pm is this symbol's increment.
  assign err_sum = {1'b0, err_q} + 17'(min_pm);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      err_q <= '0;
    end else if (acc) begin
      err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_cnt = err_q;
`endif

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;

endmodule

// File: tb/tb_viterbi_dec_hard_1_2.sv
// Bench for viterbi_dec_hard_1_2 (K=4, 17/13, D=20): golden encoder feeds the decoder,
// decoded stream must equal the encoder input bits, in order, with the specified latency.
module tb_viterbi_dec_hard_1_2;

  localparam int         D    = 20;
  localparam logic [3:0] G0M  = 4'b1111;
  localparam logic [3:0] G1M  = 4'b1011;
  localparam int         MAXN = 4096;

  typedef struct {
    int          len;
    logic [63:0] bits;
    bit          fsame;
    int          exp_run;
    int          exp_flush;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       flush;
  logic [1:0] in_sym;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       busy;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  viterbi_dec_hard_1_2 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_bit   (out_bit),
`ifdef VITERBI_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   sym_cnt  = 0;
  int   got_n    = 0;
  logic got_bit [MAXN];
  logic got_run [MAXN];
  int   got_sc  [MAXN];
  logic dat     [MAXN];
  logic [2:0] enc_s;
  vec_t tbl [10];

  // Output collector: records every decoded bit, whether RUN was active and symbols sent so far.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (got_n < MAXN) begin
        got_bit[got_n] = out_bit;
        got_run[got_n] = in_ready;
        got_sc[got_n]  = sym_cnt;
      end
      got_n = got_n + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enc_step(input logic b, output logic [1:0] sym);
    logic [3:0] r;
    r     = {b, enc_s};
    sym   = {^(r & G0M), ^(r & G1M)};
    enc_s = {b, enc_s[2:1]};
  endtask

  task automatic send_sym(input logic b, input logic [1:0] flip, input logic fl);
    logic [1:0] sym;
    enc_step(b, sym);
    in_valid = 1'b1;
    in_sym   = sym ^ flip;
    flush    = fl;
    tick();
    sym_cnt++;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 100 && busy === 1'b1; c++) tick();
    check({tag, " idle"}, int'(busy), 0);
  endtask

  task automatic run_frame(input string tag, input int len, input bit fsame, input int err_pos,
                           input int err_bit, input int gap_max, input bit do_start,
                           input int exp_run, input int exp_flush);
    int base;
    int n_run;
    int n_fl;
    int got;
    logic [1:0] flip;
    base    = got_n;
    enc_s   = '0;
    sym_cnt = 0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check({tag, " ready"}, int'(in_ready), 1);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      flip = (i == err_pos) ? ((err_bit == 1) ? 2'b10 : 2'b01) : 2'b00;
      send_sym(dat[i], flip, fsame && (i == len - 1));
    end
    if (!fsame || len == 0) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    wait_idle(tag);
    repeat (3) tick();
    got   = got_n - base;
    n_run = 0;
    n_fl  = 0;
    check({tag, " count"}, got, len);
    for (int k = 0; k < got && k < len && base + k < MAXN; k++) begin
      if (got_run[base + k]) n_run++;
      else n_fl++;
      check($sformatf("%s bit%0d", tag, k), int'(got_bit[base + k]), int'(dat[k]));
      if (k <= len - D)
        check($sformatf("%s lat%0d", tag, k), got_sc[base + k], k + D);
    end
    check({tag, " run_outputs"}, n_run, exp_run);
    check({tag, " flush_outputs"}, n_fl, exp_flush);
    check({tag, " busy_after"}, int'(busy), 0);
    check({tag, " ready_after"}, int'(in_ready), 0);
`ifdef VITERBI_ERRCNT_EN
    check({tag, " err_cnt"}, int'(err_cnt), (err_pos >= 0 && err_pos < len) ? 1 : 0);
`endif
    $display("frame %s len=%0d err_pos=%0d outputs=%0d run=%0d flush=%0d",
             tag, len, err_pos, got, n_run, n_fl);
  endtask

  initial begin
    int base;
    int len;
    int err;
    bit fs;
    int er;

    tbl[0] = '{len: 0,  bits: 64'h0,                     fsame: 1'b0, exp_run: 0,  exp_flush: 0};
    tbl[1] = '{len: 1,  bits: 64'h1,                     fsame: 1'b0, exp_run: 0,  exp_flush: 1};
    tbl[2] = '{len: 5,  bits: 64'h16,                    fsame: 1'b0, exp_run: 0,  exp_flush: 5};
    tbl[3] = '{len: 5,  bits: 64'h0D,                    fsame: 1'b1, exp_run: 0,  exp_flush: 5};
    tbl[4] = '{len: 19, bits: 64'h5A5A5,                 fsame: 1'b0, exp_run: 0,  exp_flush: 19};
    tbl[5] = '{len: 20, bits: 64'hF0F0F,                 fsame: 1'b0, exp_run: 1,  exp_flush: 19};
    tbl[6] = '{len: 20, bits: 64'h3C3C3,                 fsame: 1'b1, exp_run: 0,  exp_flush: 20};
    tbl[7] = '{len: 40, bits: 64'h0,                     fsame: 1'b0, exp_run: 21, exp_flush: 19};
    tbl[8] = '{len: 45, bits: 64'h0000_1234_5678_9AB0,   fsame: 1'b1, exp_run: 25, exp_flush: 20};
    tbl[9] = '{len: 64, bits: 64'hDEAD_BEEF_CAFE_F00D,   fsame: 1'b0, exp_run: 45, exp_flush: 19};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; flush = 1'b0; in_sym = 2'b00;
    enc_s = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 0);
    check("reset busy", int'(busy), 0);

    // Table-driven frames: short, boundary-length and same-cycle-flush cases.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < tbl[t].len; i++) dat[i] = tbl[t].bits[i];
      run_frame($sformatf("tbl%0d", t), tbl[t].len, tbl[t].fsame, -1, 1, 0, 1'b1,
                tbl[t].exp_run, tbl[t].exp_flush);
    end

    // IDLE must ignore in_valid and flush.
    base = got_n;
    in_valid = 1'b1; in_sym = 2'b11;
    repeat (4) tick();
    flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    check("idle_ignore busy", int'(busy), 0);
    check("idle_ignore ready", int'(in_ready), 0);
    check("idle_ignore outputs", got_n - base, 0);

    // 100 random bits, clean then with in_sym[1] of symbol 30 inverted.
    void'($urandom(32'hdeadbeef));
    for (int i = 0; i < 100; i++) dat[i] = 1'($urandom_range(1, 0));
    run_frame("rand100_clean", 100, 1'b0, -1, 1, 0, 1'b1, 81, 19);
    run_frame("rand100_err30", 100, 1'b0, 30, 1, 0, 1'b1, 81, 19);

    // rst mid-RUN after 10 symbols.
    base = got_n; enc_s = '0; sym_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) send_sym(dat[i], 2'b00, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst10 out_valid", int'(out_valid), 0);
    check("rst10 in_ready", int'(in_ready), 0);
    check("rst10 busy", int'(busy), 0);
    in_valid = 1'b1; repeat (5) tick();
    flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    check("rst10 no_output", got_n - base, 0);
    $display("frame rst10 outputs=%0d", got_n - base);

    // rst on the same edge as symbol 21: that symbol's output must be suppressed.
    base = got_n; enc_s = '0; sym_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 21; i++) send_sym(dat[i], 2'b00, 1'b0);
    in_valid = 1'b1; in_sym = 2'b11; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #4;
    check("rst22 out_valid", int'(out_valid), 0);
    check("rst22 busy", int'(busy), 0);
    repeat (3) tick();
    check("rst22 outputs", got_n - base, 2);
    if (got_n - base >= 2) begin
      check("rst22 bit0", int'(got_bit[base]), int'(dat[0]));
      check("rst22 bit1", int'(got_bit[base + 1]), int'(dat[1]));
    end
    $display("frame rst22 outputs=%0d", got_n - base);

    // start during FLUSH with 7 bits left, then a frame of 32 ones.
    base = got_n; enc_s = '0; sym_cnt = 0;
    for (int i = 0; i < 30; i++) dat[i] = 1'($urandom_range(1, 0));
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30; i++) send_sym(dat[i], 2'b00, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    for (int c = 0; c < 100 && (got_n - base) < 23; c++) begin
      @(negedge clk);
      #1;
    end
    check("abort pre_outputs", got_n - base, 23);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort in_ready", int'(in_ready), 1);
    check("abort busy", int'(busy), 1);
    @(negedge clk);
    #1;
    check("abort drain_stopped", int'(out_valid), 0);
    check("abort total_outputs", got_n - base, 23);
    for (int k = 0; k < 23 && base + k < MAXN; k++)
      check($sformatf("abort bit%0d", k), int'(got_bit[base + k]), int'(dat[k]));
    $display("frame abort outputs=%0d", got_n - base);
    for (int i = 0; i < 32; i++) dat[i] = 1'b1;
    run_frame("ones32", 32, 1'b0, -1, 1, 0, 1'b0, 13, 19);

    // Random frames with idle gaps, optional same-cycle flush and one isolated channel error.
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(120, 20);
      fs  = 1'($urandom_range(1, 0));
      err = -1;
      er  = $urandom_range(1, 0);
      if (len >= 40 && $urandom_range(1, 0) == 1) err = $urandom_range(len - 30, 5);
      for (int i = 0; i < len; i++) dat[i] = 1'($urandom_range(1, 0));
      run_frame($sformatf("rnd%0d", f), len, fs, err, er, 2, 1'b1,
                fs ? len - D : len - D + 1, fs ? D : D - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
